// File: rtl/dram_arbiter.sv
// Round-robin arbiter that shares one DRAM command port among NREQ requesters.
// An in-order tag FIFO sends each dram_valid response back to the requester that issued it.
module dram_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MAXOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_x,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_wdata,
    input  logic [NREQ*4-1:0]       req_we,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic [AW-1:0]           rsp_addr,
    output logic [3:0]              rsp_we,
    output logic                    dram_oe,
    output logic [AW-1:0]           dram_addr,
    output logic [DW-1:0]           dram_wdata,
    output logic [3:0]              dram_we,
    input  logic                    dram_busy,
    input  logic                    dram_valid,
    input  logic [DW-1:0]           dram_rdata,
    output logic [$clog2(MAXOUT):0] outstanding
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(MAXOUT);
    localparam logic [PW:0] FULL = (PW+1)'(MAXOUT);

    logic [IW-1:0]   r_rr;
    logic [NREQ-1:0] r_ack;
    logic            r_dram_oe;
    logic [AW-1:0]   r_dram_addr;
    logic [DW-1:0]   r_dram_wdata;
    logic [3:0]      r_dram_we;
    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic [AW-1:0]   r_rsp_addr;
    logic [3:0]      r_rsp_we;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            r_err;
    logic [IW-1:0]   r_tag_owner [MAXOUT];
    logic [AW-1:0]   r_tag_addr  [MAXOUT];
    logic [3:0]      r_tag_we    [MAXOUT];

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_rr_next;
    int              w_dist;
    int              w_best;
    logic [NREQ-1:0] w_win_1h;
    logic [NREQ-1:0] w_head_1h;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic [3:0]      w_sel_we;
    logic            w_issue;
    logic            w_pop;

    // A requester being acked this cycle still shows the request we already accepted.
    assign w_elig    = req & ~r_ack;
    assign w_issue   = w_found && !dram_busy && ((r_count < FULL) || dram_valid);
    assign w_pop     = dram_valid && (r_count != '0);
    assign w_rr_next = (w_win == IW'(NREQ-1)) ? '0 : w_win + IW'(1);

    // Winner is the eligible requester at the smallest circular distance from r_rr.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_found = 1'b0;
        w_win   = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i >= int'(r_rr)) ? i - int'(r_rr) : i + NREQ - int'(r_rr);
            if (w_elig[i] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_win   = IW'(i);
            end
        end
    end

    always_comb begin
        w_win_1h    = '0;
        w_head_1h   = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_win_1h[i] = 1'b1;
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
                w_sel_we    = req_we[i*4 +: 4];
            end
            if (r_tag_owner[r_rd_ptr] == IW'(i)) begin
                w_head_1h[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_x) begin
            r_rr         <= '0;
            r_ack        <= '0;
            r_dram_oe    <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
            r_dram_we    <= '0;
        end else begin
            r_ack     <= w_issue ? w_win_1h : '0;
            r_dram_oe <= w_issue;
            if (w_issue) begin
                r_rr         <= w_rr_next;
                r_dram_addr  <= w_sel_addr;
                r_dram_wdata <= w_sel_wdata;
                r_dram_we    <= w_sel_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_addr  <= '0;
            r_rsp_we    <= '0;
        end else begin
            if (w_issue) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A response with nothing in flight is dropped and remembered.
            if (dram_valid && (r_count == '0)) r_err <= 1'b1;
            r_rsp_valid <= w_pop ? w_head_1h : '0;
            if (w_pop) begin
                r_rsp_rdata <= dram_rdata;
                r_rsp_addr  <= r_tag_addr[r_rd_ptr];
                r_rsp_we    <= r_tag_we[r_rd_ptr];
            end
        end
    end

    // NOTE: tag storage is not reset; entries are only read while r_count says they are valid.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_owner[r_wr_ptr] <= w_win;
            r_tag_addr[r_wr_ptr]  <= w_sel_addr;
            r_tag_we[r_wr_ptr]    <= w_sel_we;
        end
    end

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_x) !$rose(r_err))
        else $warning("dram_arbiter: dram_valid arrived with no command outstanding");

    assign ack         = r_ack;
    assign dram_oe     = r_dram_oe;
    assign dram_addr   = r_dram_addr;
    assign dram_wdata  = r_dram_wdata;
    assign dram_we     = r_dram_we;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_we      = r_rsp_we;
    assign outstanding = r_count;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_dram_arbiter;
    localparam int NREQ = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXOUT = 4;

    logic                clk = 1'b0;
    logic                rst_x = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ*4-1:0]   req_we;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic [AW-1:0]       rsp_addr;
    logic [3:0]          rsp_we;
    logic                dram_oe;
    logic [AW-1:0]       dram_addr;
    logic [DW-1:0]       dram_wdata;
    logic [3:0]          dram_we;
    logic                dram_busy = 1'b0;
    logic                dram_valid = 1'b0;
    logic [DW-1:0]       dram_rdata = '0;
    logic [2:0]          outstanding;

    logic [AW-1:0] a_addr  [NREQ];
    logic [DW-1:0] a_wdata [NREQ];
    logic [3:0]    a_we    [NREQ];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = a_addr[i];
            req_wdata[i*DW +: DW] = a_wdata[i];
            req_we[i*4 +: 4]      = a_we[i];
        end
    end

    dram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst_x(rst_x), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_we(req_we), .ack(ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_addr(rsp_addr), .rsp_we(rsp_we), .dram_oe(dram_oe), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_busy(dram_busy),
        .dram_valid(dram_valid), .dram_rdata(dram_rdata), .outstanding(outstanding)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic default_ops();
        a_addr[0] = 32'h0000_00A0; a_wdata[0] = 32'h1000_0000; a_we[0] = 4'h0;
        a_addr[1] = 32'h0000_0100; a_wdata[1] = 32'h1000_0001; a_we[1] = 4'h0;
        a_addr[2] = 32'h0000_02B0; a_wdata[2] = 32'h1000_0002; a_we[2] = 4'hF;
    endtask

    task automatic do_reset();
        req = '0; dram_busy = 1'b0; dram_valid = 1'b0; dram_rdata = '0;
        default_ops();
        #2 rst_x = 1'b0;
        step();
        step();
        #3 rst_x = 1'b1;
        step();
    endtask

    typedef struct {
        logic [2:0]  req;
        logic        busy;
        logic        valid;
        logic [31:0] rdata;
        logic [2:0]  ack;
        logic        oe;
        logic [31:0] daddr;
        logic [3:0]  dwe;
        logic [2:0]  rv;
        logic [31:0] rrd;
        logic [31:0] raddr;
        logic [3:0]  rwe;
        logic [2:0]  outst;
    } vec_t;

    vec_t vecs[16];

    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic [3:0]  we;
    } tag_t;

    tag_t        tq[$];
    int          m_rr;
    logic [2:0]  e_ack, e_rv;
    logic        e_oe;
    logic [31:0] e_daddr, e_dwdata, e_rrd, e_raddr;
    logic [3:0]  e_dwe, e_rwe;

    // Reference: the first requesting port at or after the pointer wins, responses
    // retire in issue order from a queue of {owner, addr, we}.
    task automatic model_step();
        int   win;
        int   idx;
        bit   can;
        tag_t t;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (win < 0 && req[idx] && !e_ack[idx]) win = idx;
        end
        can = (win >= 0) && !dram_busy && (tq.size() < MAXOUT || dram_valid);
        e_rv = '0;
        if (dram_valid && tq.size() > 0) begin
            t = tq.pop_front();
            e_rv = 3'(1) << t.owner;
            e_raddr = t.addr;
            e_rwe = t.we;
            e_rrd = dram_rdata;
        end
        if (can) begin
            t.owner = win; t.addr = a_addr[win]; t.we = a_we[win];
            tq.push_back(t);
            e_ack = 3'(1) << win;
            e_oe = 1'b1;
            e_daddr = a_addr[win]; e_dwdata = a_wdata[win]; e_dwe = a_we[win];
            m_rr = (win + 1) % NREQ;
        end else begin
            e_ack = '0;
            e_oe = 1'b0;
        end
    endtask

    initial begin
        int cnt[NREQ];
        default_ops();
        do_reset();
        check("reset ack", ack, 0);
        check("reset oe", dram_oe, 0);
        check("reset outstanding", outstanding, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset dram_addr", dram_addr, 0);
        check("reset rsp_rdata", rsp_rdata, 0);

        // Single read, out-of-turn routing, then a pointer-priority round.
        vecs[0]  = '{3'b010, 0, 0, 0,            3'b010, 1, 32'h100, 4'h0, 3'b000, 0, 0, 0, 1};
        vecs[1]  = '{3'b010, 0, 0, 0,            3'b000, 0, 0, 0,       3'b000, 0, 0, 0, 1};
        vecs[2]  = '{3'b000, 0, 0, 0,            3'b000, 0, 0, 0,       3'b000, 0, 0, 0, 1};
        vecs[3]  = '{3'b000, 0, 1, 32'hDEADBEEF, 3'b000, 0, 0, 0,       3'b010, 32'hDEADBEEF, 32'h100, 4'h0, 0};
        vecs[4]  = '{3'b001, 0, 0, 0,            3'b001, 1, 32'h0A0, 4'h0, 3'b000, 0, 0, 0, 1};
        vecs[5]  = '{3'b100, 0, 0, 0,            3'b100, 1, 32'h2B0, 4'hF, 3'b000, 0, 0, 0, 2};
        vecs[6]  = '{3'b010, 0, 0, 0,            3'b010, 1, 32'h100, 4'h0, 3'b000, 0, 0, 0, 3};
        vecs[7]  = '{3'b000, 0, 1, 32'h11111111, 3'b000, 0, 0, 0,       3'b001, 32'h11111111, 32'h0A0, 4'h0, 2};
        vecs[8]  = '{3'b000, 0, 1, 32'h22222222, 3'b000, 0, 0, 0,       3'b100, 32'h22222222, 32'h2B0, 4'hF, 1};
        vecs[9]  = '{3'b000, 0, 1, 32'h33333333, 3'b000, 0, 0, 0,       3'b010, 32'h33333333, 32'h100, 4'h0, 0};
        vecs[10] = '{3'b111, 0, 0, 0,            3'b100, 1, 32'h2B0, 4'hF, 3'b000, 0, 0, 0, 1};
        vecs[11] = '{3'b011, 0, 0, 0,            3'b001, 1, 32'h0A0, 4'h0, 3'b000, 0, 0, 0, 2};
        vecs[12] = '{3'b010, 0, 0, 0,            3'b010, 1, 32'h100, 4'h0, 3'b000, 0, 0, 0, 3};
        vecs[13] = '{3'b000, 0, 1, 32'h44,       3'b000, 0, 0, 0,       3'b100, 32'h44, 32'h2B0, 4'hF, 2};
        vecs[14] = '{3'b000, 0, 1, 32'h55,       3'b000, 0, 0, 0,       3'b001, 32'h55, 32'h0A0, 4'h0, 1};
        vecs[15] = '{3'b000, 0, 1, 32'h66,       3'b000, 0, 0, 0,       3'b010, 32'h66, 32'h100, 4'h0, 0};
        for (int k = 0; k < 16; k++) begin
            req = vecs[k].req; dram_busy = vecs[k].busy;
            dram_valid = vecs[k].valid; dram_rdata = vecs[k].rdata;
            step();
            check($sformatf("vec%0d ack", k), ack, vecs[k].ack);
            check($sformatf("vec%0d oe", k), dram_oe, vecs[k].oe);
            check($sformatf("vec%0d rsp_valid", k), rsp_valid, vecs[k].rv);
            check($sformatf("vec%0d outstanding", k), outstanding, vecs[k].outst);
            if (vecs[k].oe) begin
                check($sformatf("vec%0d dram_addr", k), dram_addr, vecs[k].daddr);
                check($sformatf("vec%0d dram_we", k), dram_we, vecs[k].dwe);
            end
            if (vecs[k].rv != 0) begin
                check($sformatf("vec%0d rsp_rdata", k), rsp_rdata, vecs[k].rrd);
                check($sformatf("vec%0d rsp_addr", k), rsp_addr, vecs[k].raddr);
                check($sformatf("vec%0d rsp_we", k), rsp_we, vecs[k].rwe);
            end
        end
        req = '0; dram_valid = 1'b0;

        // Round-robin fairness with all three requesting continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int g = 0; g < 30; g++) begin
            req = 3'b111; dram_valid = (g > 0); dram_rdata = g;
            step();
            check($sformatf("rr ack g%0d", g), ack, 3'(1) << (g % 3));
            for (int i = 0; i < NREQ; i++) if (ack[i]) cnt[i]++;
        end
        req = '0; dram_valid = 1'b1;
        step();
        dram_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) check($sformatf("rr grants r%0d", i), cnt[i], 10);
        check("rr drained", outstanding, 0);

        // Busy stall: no issue while busy, issue right after it drops.
        do_reset();
        req = 3'b001; dram_busy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("busy ack c%0d", c), ack, 0);
            check($sformatf("busy oe c%0d", c), dram_oe, 0);
        end
        dram_busy = 1'b0;
        step();
        check("busy release ack", ack, 3'b001);
        check("busy release oe", dram_oe, 1);
        check("busy release addr", dram_addr, 32'h0A0);
        req = '0;

        // Full FIFO: four writes, fifth waits until a response frees a slot.
        do_reset();
        a_we[0] = 4'h1; a_we[1] = 4'h3;
        for (int c = 0; c < 4; c++) begin
            req = 3'b111;
            step();
            check($sformatf("fill ack c%0d", c), ack, 3'(1) << (c % 3));
            check($sformatf("fill outstanding c%0d", c), outstanding, c + 1);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("full ack c%0d", c), ack, 0);
            check($sformatf("full outstanding c%0d", c), outstanding, 4);
        end
        dram_valid = 1'b1; dram_rdata = 32'h77;
        step();
        dram_valid = 1'b0; req = '0;
        check("full push+pop ack", ack, 3'b010);
        check("full push+pop oe", dram_oe, 1);
        check("full push+pop rsp_valid", rsp_valid, 3'b001);
        check("full push+pop rsp_we", rsp_we, 4'h1);
        check("full push+pop outstanding", outstanding, 4);

        // Asynchronous reset with two commands in flight, then a stray response.
        do_reset();
        req = 3'b011;
        step();
        step();
        check("pre-reset outstanding", outstanding, 2);
        req = '0;
        #1 rst_x = 1'b0;
        #1;
        check("async reset ack", ack, 0);
        check("async reset oe", dram_oe, 0);
        check("async reset outstanding", outstanding, 0);
        #4 rst_x = 1'b1;
        step();
        dram_valid = 1'b1; dram_rdata = 32'hBAD;
        step();
        dram_valid = 1'b0;
        check("stray rsp_valid", rsp_valid, 0);
        check("stray outstanding", outstanding, 0);
        check("stray error flag", dut.r_err, 1);
        step();
        check("stray rsp_valid later", rsp_valid, 0);

        // Randomized traffic against the reference model.
        do_reset();
        tq.delete();
        m_rr = 0; e_ack = '0; e_oe = 1'b0; e_rv = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                end else if (!req[i]) begin
                    req[i] = ($urandom_range(0, 2) == 0);
                end
                if (e_ack[i] || !req[i]) begin
                    a_addr[i] = $urandom; a_wdata[i] = $urandom; a_we[i] = 4'($urandom);
                end
            end
            dram_busy = ($urandom_range(0, 3) == 0);
            dram_valid = (tq.size() > 0) && ($urandom_range(0, 1) == 1);
            dram_rdata = $urandom;
            model_step();
            step();
            check($sformatf("rand%0d ack", cyc), ack, e_ack);
            check($sformatf("rand%0d oe", cyc), dram_oe, e_oe);
            check($sformatf("rand%0d rsp_valid", cyc), rsp_valid, e_rv);
            check($sformatf("rand%0d outstanding", cyc), outstanding, tq.size());
            if (e_oe) begin
                check($sformatf("rand%0d dram_addr", cyc), dram_addr, e_daddr);
                check($sformatf("rand%0d dram_wdata", cyc), dram_wdata, e_dwdata);
                check($sformatf("rand%0d dram_we", cyc), dram_we, e_dwe);
            end
            if (e_rv != 0) begin
                check($sformatf("rand%0d rsp_rdata", cyc), rsp_rdata, e_rrd);
                check($sformatf("rand%0d rsp_addr", cyc), rsp_addr, e_raddr);
                check($sformatf("rand%0d rsp_we", cyc), rsp_we, e_rwe);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAM command port among NREQ requesters: program loader, data-cache miss/write path, and a spare port for a future I-refill or DMA engine.
- Grants are round-robin, and accepted commands are issued to the DRAM controller.
- Each command's owner and byte-enable are recorded in an in-order tag FIFO, so every dram_valid response is routed back to the requester that issued it.
- Sits between the requesters and the DRAM controller in the top level.

Parameters:
- NREQ, 3, number of requesters (2..4); index 0 has the highest priority out of reset.
- AW, 32, address width.
- DW, 32, data width.
- MAXOUT, 4, maximum commands outstanding at the DRAM (tag FIFO depth, power of 2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_x  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester command request, level; held until ack.
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW+:AW].
- req_wdata  in  NREQ*DW  flattened write data.
- req_we  in  NREQ*4  flattened byte write enables; all-zero = read.
- ack  out  NREQ  one-hot, 1-cycle pulse: command accepted this cycle.
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: response for the oldest command of requester i.
- rsp_rdata  out  DW  response data, valid with any rsp_valid bit.
- rsp_addr  out  AW  address of the completed command.
- rsp_we  out  4  byte enables of the completed command.
- dram_oe  out  1  command strobe to the DRAM controller.
- dram_addr  out  AW  command address.
- dram_wdata  out  DW  command write data.
- dram_we  out  4  command byte enables.
- dram_busy  in  1  controller cannot accept a command this cycle.
- dram_valid  in  1  one response per issued command (read or write), in issue order.
- dram_rdata  in  DW  response data (don't-care for writes).
- outstanding  out  log2(MAXOUT)+1  number of commands in flight, for debug.

Behaviour:
- Reset (rst_x low, async):
  - ack, rsp_valid, dram_oe = 0; dram_addr/wdata/we = 0.
  - Tag FIFO empty; outstanding = 0.
  - Round-robin pointer = 0.
  - rsp_rdata/rsp_addr/rsp_we = 0.
- Deassertion is synchronized externally; the block must tolerate release on any edge.
- Issue condition, per cycle: can_issue = |req && !dram_busy && (outstanding < MAXOUT || dram_valid).
- Grant selection:
  - Search starts at index rr and wraps modulo NREQ; the first i with req[i] wins.
  - On grant, rr <= (winner+1) mod NREQ; with no grant, rr holds.
- Issue is registered, 1-cycle latency:
  - In the cycle after can_issue, dram_oe=1 with the winner's addr/wdata/we, and ack[winner]=1.
  - ack and dram_oe are asserted in the same cycle.
  - Requester i must keep req[i] and its operands stable until it sees ack[i].
  - Sampling must not double-grant: a requester acked in cycle t is not eligible in cycle t itself (req seen at t is treated as the already-accepted command). A new command requires req still high at t+1.
- Back-to-back issue: one command per cycle is allowed while dram_busy=0 and the FIFO is not full.
- Tag FIFO entry on issue: {owner id, addr, we}.
- dram_valid handling:
  - The head entry is popped.
  - Next cycle: rsp_valid[owner]=1, rsp_addr/rsp_we from the entry, rsp_rdata=dram_rdata registered.
  - Response latency is one cycle after dram_valid.
- Simultaneous push and pop: outstanding is unchanged; a full FIFO accepts the push because a pop frees a slot.
- FIFO full (outstanding==MAXOUT) with no dram_valid: no grant; req stays pending; rr is unchanged.
- dram_valid with an empty FIFO is a protocol error:
  - Response is dropped; no rsp_valid; outstanding stays 0.
  - Sticky error flag held internally; assertion in simulation.
- dram_busy is sampled only at grant time. dram_oe is never asserted during a cycle the block registered as busy.
- The pointer wraps at NREQ-1 -> 0. Non-power-of-2 NREQ is supported.
- Reset mid-operation: all in-flight tags are lost. Responses arriving after reset fall under the empty-FIFO rule.

Test Plan:
1. Single read: req[1]=1, addr=0x100, we=0, dram_busy=0 -> next cycle ack=3'b010, dram_oe=1, dram_addr=0x100. dram_valid with rdata=0xDEADBEEF two cycles later -> rsp_valid=3'b010, rsp_rdata=0xDEADBEEF, rsp_addr=0x100, outstanding back to 0.
2. Round-robin fairness: req=3'b111 held continuously, always re-requesting -> acks cycle as 001, 010, 100, 001, ...; no requester is starved over 30 grants (10 each).
3. Busy stall: req[0] with dram_busy=1 for 5 cycles -> no ack or dram_oe during those cycles; ack on the first cycle after busy drops; operands unchanged.
4. Full FIFO: MAXOUT=4, issue 4 writes without any dram_valid -> 5th req is held, outstanding=4. Pulse dram_valid -> the 5th is granted the same cycle (push+pop), outstanding stays 4; first response goes to the first issuer with its we.
5. Out-of-turn routing: issue r0 (read, A), r2 (write, B, we=4'hF), r1 (read, C) -> three dram_valid pulses produce rsp_valid 001, 100, 010 in order, with matching rsp_addr A, B, C.
6. Async reset mid-flight: 2 outstanding, rst_x low for 1 cycle between edges -> outputs 0 immediately, outstanding=0. A stray dram_valid afterwards produces no rsp_valid and the error flag is set.
